i2c_bus_arbiter: RTL

//  Shares one open-drain I2C bus (SCL/SDA) between NUM_REQ I2C masters such as ADV7513 init, ADV7513 reg read and camera config.

---
 rtl/i2c_bus_arbiter_pkg.sv | 22 ++
 rtl/i2c_bus_arbiter_if.sv | 30 +++
 rtl/i2c_bus_arbiter_rr_priority_encoder.sv | 37 +++
 rtl/i2c_bus_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared constants and helpers for the I2C bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_arb_pkg;

   // Arbiter FSM encoding, kept as plain constants for legacy tools.
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_GUARD = 2'd2;

   // 5us of released bus at 50MHz between consecutive owners.
   localparam logic [15:0] BUS_FREE_CYCLES_DEF = 16'd250;

   // Ceiling log2, used to size counters from their terminal counts.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Bundle between the per-function I2C engines and the bus arbiter.
// Latency: n/a (wires only).
// Backpressure: req is held until done; grant is the only flow control.
interface i2c_bus_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int OWNER_W = 3
);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] done;
   logic [NUM_REQ-1:0] scl_oe_in;
   logic [NUM_REQ-1:0] sda_oe_in;
   logic [NUM_REQ-1:0] grant;
   logic               scl_oe;
   logic               sda_oe;
   logic               busy;
   logic [OWNER_W-1:0] owner;
   logic               timeout_err;

   // Arbiter side.
   modport slave (
      input  req, done, scl_oe_in, sda_oe_in,
      output grant, scl_oe, sda_oe, busy, owner, timeout_err
   );

   // Requester / pad side.
   modport master (
      output req, done, scl_oe_in, sda_oe_in,
      input  grant, scl_oe, sda_oe, busy, owner, timeout_err
   );
endinterface

// File: rtl/i2c_bus_arbiter_rr_priority_encoder.sv
// Round-robin priority encoder: first set req at or above rr_ptr, wrapping.
// Latency: combinational.
// Backpressure: none; valid=0 when no request is pending.
module rr_priority_encoder
   import i2c_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int OWNER_W = 3
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [OWNER_W-1:0] rr_ptr,
   output logic               valid,
   output logic [OWNER_W-1:0] idx,
   output logic [NUM_REQ-1:0] onehot
);

   // Walk offsets 0..NUM_REQ-1 from rr_ptr; the first hit wins.
   always_comb begin
      int cand;
      cand   = 0;
      valid  = 1'b0;
      idx    = '0;
      onehot = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!valid && (j == cand) && req[j]) begin
               valid     = 1'b1;
               idx       = OWNER_W'(j);
               onehot[j] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner of one open-drain I2C bus; muxes owner pull-downs to pads.
// Latency: grant 1 clk after req sampled; scl_oe/sda_oe combinational from owner.
// Backpressure: losers hold req; bus-free guard after each tenure. Macro I2C_ARB_TIMEOUT_EN adds tenure limit.
module i2c_bus_arbiter
   import i2c_arb_pkg::*;
#(
`ifdef I2C_ARB_TIMEOUT_EN
   parameter logic [31:0] TIMEOUT_CYCLES  = 32'd5000000,
`endif
   parameter int          NUM_REQ         = 3,
   parameter int          OWNER_W         = 3,
   parameter logic [15:0] BUS_FREE_CYCLES = BUS_FREE_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             reset,
   i2c_bus_arbiter_if.slave bus
);

   localparam int GUARD_W = (clog2(int'(BUS_FREE_CYCLES) + 1) < 1) ? 1 : clog2(int'(BUS_FREE_CYCLES) + 1);

   logic [1:0]         state;
   logic [NUM_REQ-1:0] grant_q;
   logic [OWNER_W-1:0] owner_q;
   logic [OWNER_W-1:0] rr_ptr;
   logic [GUARD_W-1:0] guard_cnt;

   logic               enc_valid;
   logic [OWNER_W-1:0] enc_idx;
   logic [NUM_REQ-1:0] enc_onehot;

   logic               own_req;
   logic               own_done;
   logic               own_scl;
   logic               own_sda;
   logic               ten_hit;
   logic               exit_now;
   logic [OWNER_W-1:0] next_ptr;

   rr_priority_encoder #(
      .NUM_REQ (NUM_REQ),
      .OWNER_W (OWNER_W)
   ) u_rr_enc (
      .req    (bus.req),
      .rr_ptr (rr_ptr),
      .valid  (enc_valid),
      .idx    (enc_idx),
      .onehot (enc_onehot)
   );

   // Pick the owner's lines out of the per-requester vectors; others are ignored.
   always_comb begin
      own_req  = 1'b0;
      own_done = 1'b0;
      own_scl  = 1'b0;
      own_sda  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == OWNER_W'(i)) begin
            own_req  = bus.req[i];
            own_done = bus.done[i];
            own_scl  = bus.scl_oe_in[i];
            own_sda  = bus.sda_oe_in[i];
         end
      end
   end

   assign next_ptr = (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + OWNER_W'(1);
   assign exit_now = own_done | ~own_req | ten_hit;

   // Arbitration FSM: grant, hold for the tenure, then keep the bus released for the guard time.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         grant_q   <= '0;
         owner_q   <= '0;
         rr_ptr    <= '0;
         guard_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (enc_valid) begin
                  grant_q <= enc_onehot;
                  owner_q <= enc_idx;
                  state   <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (exit_now) begin
                  grant_q   <= '0;
                  rr_ptr    <= next_ptr;
                  guard_cnt <= '0;
                  state     <= S_GUARD;
               end
            end
            S_GUARD: begin
               if (guard_cnt == GUARD_W'(BUS_FREE_CYCLES - 16'd1)) begin
                  state <= S_IDLE;
               end else begin
                  guard_cnt <= guard_cnt + GUARD_W'(1);
               end
            end
            default: begin
               state   <= S_IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

`ifdef I2C_ARB_TIMEOUT_EN
   logic [31:0] ten_cnt;
   logic        timeout_q;

   assign ten_hit = (state == S_GRANT) && (ten_cnt == TIMEOUT_CYCLES - 32'd1);

   // Tenure counter restarts on every grant; hitting the limit forces a release and latches the error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ten_cnt   <= '0;
         timeout_q <= 1'b0;
      end else if (state == S_IDLE) begin
         ten_cnt <= '0;
      end else if (state == S_GRANT) begin
         ten_cnt <= ten_cnt + 32'd1;
         if (ten_hit) timeout_q <= 1'b1;
      end
   end

   assign bus.timeout_err = timeout_q;
`else
   assign ten_hit         = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif

   // Only the owner's pull-downs reach the pads, and only while it holds the bus.
   assign bus.scl_oe = (state == S_GRANT) & own_scl;
   assign bus.sda_oe = (state == S_GRANT) & own_sda;
   assign bus.grant  = grant_q;
   assign bus.owner  = owner_q;
   assign bus.busy   = (state == S_GRANT) | (state == S_GUARD);

endmodule
